ysyx_22050854_operand_stage: RTL and testbench

//  Parametrised ID->EX operand stage: selects ALU operand 1/2 (reg/PC/imm/const),

---
 rtl/ysyx_22050854_operand_stage_if.sv | 43 ++++
 rtl/ysyx_22050854_operand_stage.sv | 113 +++++++++++
 tb/tb_ysyx_22050854_operand_stage.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050854_operand_stage_if.sv
// rtl/ysyx_22050854_operand_stage_if.sv - decode/forwarding/ALU-side bundle of the ID->EX operand stage
// master drives ops, forwarding state and out_ready; slave is the operand stage.
interface ysyx_22050854_operand_stage_if #(
  parameter int XLEN    = 64,
  parameter int PC_W    = 32,
  parameter int NUM_FWD = 3
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [PC_W-1:0]         in_pc;
  logic [XLEN-1:0]         in_imm;
  logic [4:0]              in_rs1_idx;
  logic [4:0]              in_rs2_idx;
  logic [XLEN-1:0]         in_rs1_data;
  logic [XLEN-1:0]         in_rs2_data;
  logic [1:0]              in_src1_sel;
  logic [1:0]              in_src2_sel;
  logic                    in_rs2_use;
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [NUM_FWD-1:0]      fwd_pending;
  logic [5*NUM_FWD-1:0]    fwd_rd;
  logic [XLEN*NUM_FWD-1:0] fwd_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         out_src1;
  logic [XLEN-1:0]         out_src2;
  logic [XLEN-1:0]         out_rs2_data;

  modport master (
    output flush, in_valid, in_pc, in_imm, in_rs1_idx, in_rs2_idx, in_rs1_data, in_rs2_data,
           in_src1_sel, in_src2_sel, in_rs2_use, fwd_valid, fwd_pending, fwd_rd, fwd_data,
           out_ready,
    input  in_ready, out_valid, out_src1, out_src2, out_rs2_data
  );

  modport slave (
    input  flush, in_valid, in_pc, in_imm, in_rs1_idx, in_rs2_idx, in_rs1_data, in_rs2_data,
           in_src1_sel, in_src2_sel, in_rs2_use, fwd_valid, fwd_pending, fwd_rd, fwd_data,
           out_ready,
    output in_ready, out_valid, out_src1, out_src2, out_rs2_data
  );
endinterface

// File: rtl/ysyx_22050854_operand_stage.sv
// rtl/ysyx_22050854_operand_stage.sv - ID->EX operand select, RAW forwarding/interlock, registered output
// YSYX_22050854_FWD_EN enables bypass from fwd_data; otherwise any live writer match interlocks.
module ysyx_22050854_operand_stage #(
  parameter int XLEN       = 64,
  parameter int PC_W       = 32,
  parameter int NUM_FWD    = 3,
  parameter int INST_BYTES = 4
) (
  input logic clk,
  input logic rst_n,
  ysyx_22050854_operand_stage_if.slave bus
);

  typedef struct packed {
    logic            hit;
    logic            pend;
    logic [XLEN-1:0] data;
  } fwd_hit_t;

  // Descending scan so the youngest (lowest index) matching stage is the last to assign.
  function automatic fwd_hit_t lookup(
    input logic [4:0]              r,
    input logic [NUM_FWD-1:0]      fv,
    input logic [NUM_FWD-1:0]      fp,
    input logic [5*NUM_FWD-1:0]    frd,
    input logic [XLEN*NUM_FWD-1:0] fd
  );
    fwd_hit_t res;
    res = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fv[i] && frd[5*i +: 5] == r && r != 5'd0) begin
        res.hit  = 1'b1;
        res.pend = fp[i];
        res.data = fd[XLEN*i +: XLEN];
      end
    end
    return res;
  endfunction

  fwd_hit_t        m1, m2;
  logic            rs1_used, rs2_used;
  logic            hazard, load;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] src1_d, src2_d;
  logic            valid_q;
  logic [XLEN-1:0] src1_q, src2_q, rs2_q;

  assign m1 = lookup(bus.in_rs1_idx, bus.fwd_valid, bus.fwd_pending, bus.fwd_rd, bus.fwd_data);
  assign m2 = lookup(bus.in_rs2_idx, bus.fwd_valid, bus.fwd_pending, bus.fwd_rd, bus.fwd_data);

  assign rs1_used = (bus.in_src1_sel == 2'd0);
  assign rs2_used = bus.in_rs2_use;

`ifdef YSYX_22050854_FWD_EN
  assign rs1_val = m1.hit ? m1.data : bus.in_rs1_data;
  assign rs2_val = m2.hit ? m2.data : bus.in_rs2_data;
  assign hazard  = (rs1_used & m1.hit & m1.pend) | (rs2_used & m2.hit & m2.pend);
`else
  // Without bypass a live writer must drain out of every forwarding stage first.
  logic unused_fwd;
  assign unused_fwd = ^{m1.pend, m1.data, m2.pend, m2.data};
  assign rs1_val    = bus.in_rs1_data;
  assign rs2_val    = bus.in_rs2_data;
  assign hazard     = (rs1_used & m1.hit) | (rs2_used & m2.hit);
`endif

  always_comb begin
    src1_d = '0;
    case (bus.in_src1_sel)
      2'd0:    src1_d = rs1_val;
      2'd1:    src1_d = {{(XLEN-PC_W){1'b0}}, bus.in_pc};
      default: src1_d = '0;
    endcase
  end

  always_comb begin
    src2_d = '0;
    case (bus.in_src2_sel)
      2'd0:    src2_d = rs2_val;
      2'd1:    src2_d = bus.in_imm;
      2'd2:    src2_d = XLEN'(INST_BYTES);
      default: src2_d = '0;
    endcase
  end

  assign bus.in_ready = (~valid_q | bus.out_ready) & ~hazard & ~bus.flush;
  assign load         = bus.in_valid & bus.in_ready;

  // Flush only drops valid; data registers keep their last contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      rs2_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      rs2_q   <= rs2_val;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_src1     = src1_q;
  assign bus.out_src2     = src2_q;
  assign bus.out_rs2_data = rs2_q;

endmodule

// File: tb/tb_ysyx_22050854_operand_stage.sv
// tb/tb_ysyx_22050854_operand_stage.sv - directed and randomized bench for the operand stage
// Reference model resolves sources by first-youngest-match search and tracks the output register.
module tb_ysyx_22050854_operand_stage;
  localparam int XLEN       = 64;
  localparam int PC_W       = 32;
  localparam int NUM_FWD    = 3;
  localparam int INST_BYTES = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ysyx_22050854_operand_stage_if #(.XLEN(XLEN), .PC_W(PC_W), .NUM_FWD(NUM_FWD)) bus();

  ysyx_22050854_operand_stage #(
    .XLEN(XLEN), .PC_W(PC_W), .NUM_FWD(NUM_FWD), .INST_BYTES(INST_BYTES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic            m_valid;
  logic [XLEN-1:0] m_src1, m_src2, m_rs2;

  function automatic void resolve(input logic [4:0] r, input logic [XLEN-1:0] rf, input logic used,
                                  output logic [XLEN-1:0] val, output logic hz);
    logic found;
    found = 1'b0;
    val   = rf;
    hz    = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!found && r != 5'd0 && bus.fwd_valid[i] && bus.fwd_rd[5*i +: 5] == r) begin
        found = 1'b1;
`ifdef YSYX_22050854_FWD_EN
        val = bus.fwd_data[XLEN*i +: XLEN];
        hz  = used && bus.fwd_pending[i];
`else
        hz  = used;
`endif
      end
    end
  endfunction

  function automatic void model_eval(output logic [XLEN-1:0] s1, output logic [XLEN-1:0] s2,
                                     output logic [XLEN-1:0] r2, output logic rdy);
    logic [XLEN-1:0] r1;
    logic h1, h2;
    resolve(bus.in_rs1_idx, bus.in_rs1_data, bus.in_src1_sel == 2'd0, r1, h1);
    resolve(bus.in_rs2_idx, bus.in_rs2_data, bus.in_rs2_use, r2, h2);
    case (bus.in_src1_sel)
      2'd0:    s1 = r1;
      2'd1:    s1 = {32'h0, bus.in_pc};
      default: s1 = 64'h0;
    endcase
    case (bus.in_src2_sel)
      2'd0:    s2 = r2;
      2'd1:    s2 = bus.in_imm;
      2'd2:    s2 = 64'd4;
      default: s2 = 64'h0;
    endcase
    rdy = (!m_valid || bus.out_ready) && !h1 && !h2 && !bus.flush;
  endfunction

  task automatic cycle();
    logic [XLEN-1:0] s1, s2, r2;
    logic rdy;
    model_eval(s1, s2, r2, rdy);
    @(posedge clk);
    if (bus.flush) m_valid = 1'b0;
    else if (bus.in_valid && rdy) begin
      m_valid = 1'b1; m_src1 = s1; m_src2 = s2; m_rs2 = r2;
    end else if (bus.out_ready) m_valid = 1'b0;
    #1;
  endtask

  task automatic set_fwd(input int i, input logic v, input logic p, input logic [4:0] rd,
                         input logic [XLEN-1:0] d);
    bus.fwd_valid[i]            = v;
    bus.fwd_pending[i]          = p;
    bus.fwd_rd[5*i +: 5]        = rd;
    bus.fwd_data[XLEN*i +: XLEN] = d;
  endtask

  task automatic idle();
    bus.flush = 0; bus.in_valid = 0; bus.in_pc = '0; bus.in_imm = '0;
    bus.in_rs1_idx = '0; bus.in_rs2_idx = '0; bus.in_rs1_data = '0; bus.in_rs2_data = '0;
    bus.in_src1_sel = 2'd3; bus.in_src2_sel = 2'd3; bus.in_rs2_use = 0;
    bus.fwd_valid = '0; bus.fwd_pending = '0; bus.fwd_rd = '0; bus.fwd_data = '0;
    bus.out_ready = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    m_valid = 0; m_src1 = '0; m_src2 = '0; m_rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_src1 !== '0 || bus.out_src2 !== '0 || bus.out_rs2_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b s1=%h s2=%h r2=%h exp all zero",
               bus.out_valid, bus.out_src1, bus.out_src2, bus.out_rs2_data);
    end
    rst_n = 1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_pc_const();
    idle();
    bus.in_valid = 1; bus.in_src1_sel = 2'd1; bus.in_pc = 32'h8000_0000; bus.in_src2_sel = 2'd2;
    cycle();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_src1 !== 64'h8000_0000 || bus.out_src2 !== 64'd4) begin
      n_err++;
      $display("FAIL pc_const got v=%b s1=%h s2=%h exp v=1 s1=80000000 s2=4",
               bus.out_valid, bus.out_src1, bus.out_src2);
    end
    idle();
    cycle();
  endtask

  task automatic test_fwd_priority();
    idle();
    bus.in_valid = 1; bus.in_src1_sel = 2'd0; bus.in_rs1_idx = 5'd5; bus.in_rs1_data = 64'h5555;
    set_fwd(0, 1, 0, 5'd5, 64'hAA);
    set_fwd(1, 1, 0, 5'd5, 64'hBB);
    #1;
`ifdef YSYX_22050854_FWD_EN
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL fwd_ready got=%b exp=1", bus.in_ready); end
    cycle();
    n_vec++;
    if (bus.out_src1 !== 64'hAA) begin n_err++; $display("FAIL fwd_priority got=%h exp=aa", bus.out_src1); end
`else
    n_vec++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL interlock_both got=%b exp=0", bus.in_ready); end
    cycle();
    set_fwd(0, 0, 0, 5'd5, 64'hAA);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL interlock_older got=%b exp=0", bus.in_ready); end
    cycle();
    set_fwd(1, 0, 0, 5'd5, 64'hBB);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL interlock_clear got=%b exp=1", bus.in_ready); end
    cycle();
    n_vec++;
    if (bus.out_src1 !== 64'h5555) begin n_err++; $display("FAIL interlock_regfile got=%h exp=5555", bus.out_src1); end
`endif
    idle();
    cycle();
  endtask

  task automatic test_pending();
    idle();
    bus.in_valid = 1; bus.in_src1_sel = 2'd2; bus.in_src2_sel = 2'd0; bus.in_rs2_use = 1;
    bus.in_rs2_idx = 5'd7; bus.in_rs2_data = 64'h9999;
    set_fwd(0, 1, 1, 5'd7, 64'h0);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++;
      if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL pending_stall[%0d] got=%b exp=0", k, bus.in_ready); end
      cycle();
    end
    set_fwd(0, 1, 0, 5'd7, 64'h1234);
`ifndef YSYX_22050854_FWD_EN
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL pending_interlock got=%b exp=0", bus.in_ready); end
    cycle();
    set_fwd(0, 0, 0, 5'd7, 64'h1234);
`endif
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL pending_release got=%b exp=1", bus.in_ready); end
    cycle();
    n_vec++;
`ifdef YSYX_22050854_FWD_EN
    if (bus.out_rs2_data !== 64'h1234 || bus.out_src2 !== 64'h1234) begin
      n_err++; $display("FAIL pending_data got r2=%h s2=%h exp 1234", bus.out_rs2_data, bus.out_src2);
    end
`else
    if (bus.out_rs2_data !== 64'h9999 || bus.out_src2 !== 64'h9999) begin
      n_err++; $display("FAIL pending_data got r2=%h s2=%h exp 9999", bus.out_rs2_data, bus.out_src2);
    end
`endif
    idle();
    cycle();
  endtask

  task automatic test_x0();
    idle();
    bus.in_valid = 1; bus.in_src1_sel = 2'd0; bus.in_rs1_idx = 5'd0; bus.in_rs1_data = 64'hDEAD;
    set_fwd(0, 1, 1, 5'd0, 64'hFF);
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL x0_no_stall got=%b exp=1", bus.in_ready); end
    cycle();
    n_vec++;
    if (bus.out_src1 !== 64'hDEAD) begin n_err++; $display("FAIL x0_regfile got=%h exp=dead", bus.out_src1); end
    idle();
    cycle();
  endtask

  task automatic test_back_pressure();
    idle();
    bus.out_ready = 0; bus.in_valid = 1; bus.in_src1_sel = 2'd1; bus.in_pc = 32'h100;
    bus.in_src2_sel = 2'd1; bus.in_imm = 64'h55;
    cycle();
    bus.in_pc = 32'h200; bus.in_imm = 64'h66;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d] got=%b exp=0", k, bus.in_ready); end
      cycle();
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_src1 !== 64'h100 || bus.out_src2 !== 64'h55) begin
        n_err++;
        $display("FAIL hold_data[%0d] got v=%b s1=%h s2=%h exp v=1 s1=100 s2=55",
                 k, bus.out_valid, bus.out_src1, bus.out_src2);
      end
    end
    bus.out_ready = 1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready got=%b exp=1", bus.in_ready); end
    cycle();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_src1 !== 64'h200 || bus.out_src2 !== 64'h66) begin
      n_err++;
      $display("FAIL release_load got v=%b s1=%h s2=%h exp v=1 s1=200 s2=66",
               bus.out_valid, bus.out_src1, bus.out_src2);
    end
  endtask

  task automatic test_flush_reset();
    bus.in_pc = 32'h300; bus.flush = 1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got=%b exp=0", bus.in_ready); end
    cycle();
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_src1 !== 64'h200) begin
      n_err++; $display("FAIL flush got v=%b s1=%h exp v=0 s1=200", bus.out_valid, bus.out_src1);
    end
    bus.flush = 0; bus.in_pc = 32'h1234;
    cycle();
    #2;
    rst_n = 0;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.out_src1 !== '0 || bus.out_src2 !== '0 || bus.out_rs2_data !== '0) begin
      n_err++;
      $display("FAIL async_reset got v=%b s1=%h s2=%h r2=%h exp all zero",
               bus.out_valid, bus.out_src1, bus.out_src2, bus.out_rs2_data);
    end
    idle();
    m_valid = 0; m_src1 = '0; m_src2 = '0; m_rs2 = '0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_random();
    logic [XLEN-1:0] s1, s2, r2;
    logic rdy;
    for (int n = 0; n < 400; n++) begin
      bus.in_valid    = ($urandom_range(0, 9) < 7);
      bus.flush       = ($urandom_range(0, 19) == 0);
      bus.out_ready   = ($urandom_range(0, 9) < 7);
      bus.in_pc       = $urandom;
      bus.in_imm      = {$urandom, $urandom};
      bus.in_rs1_idx  = 5'($urandom_range(0, 7));
      bus.in_rs2_idx  = 5'($urandom_range(0, 7));
      bus.in_rs1_data = {$urandom, $urandom};
      bus.in_rs2_data = {$urandom, $urandom};
      bus.in_src1_sel = 2'($urandom_range(0, 3));
      bus.in_src2_sel = 2'($urandom_range(0, 3));
      bus.in_rs2_use  = $urandom_range(0, 1);
      for (int i = 0; i < NUM_FWD; i++)
        set_fwd(i, ($urandom_range(0, 9) < 4), ($urandom_range(0, 3) == 0),
                5'($urandom_range(0, 7)), {$urandom, $urandom});
      #1;
      model_eval(s1, s2, r2, rdy);
      n_vec++;
      if (bus.in_ready !== rdy) begin n_err++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, bus.in_ready, rdy); end
      cycle();
      n_vec++;
      if (bus.out_valid !== m_valid || bus.out_src1 !== m_src1 || bus.out_src2 !== m_src2 ||
          bus.out_rs2_data !== m_rs2) begin
        n_err++;
        $display("FAIL rand_out[%0d] got v=%b s1=%h s2=%h r2=%h exp v=%b s1=%h s2=%h r2=%h", n,
                 bus.out_valid, bus.out_src1, bus.out_src2, bus.out_rs2_data,
                 m_valid, m_src1, m_src2, m_rs2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pc_const();
    test_fwd_priority();
    test_pending();
    test_x0();
    test_back_pressure();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
